// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, ALU opcode constants for the
// shift operations, and the state encoding of the sequential right shifter.
package alu_pkg;

  localparam int unsigned SR_WIDTH   = 32;
  localparam int unsigned SR_SHAMT_W = 5;   // log2(SR_WIDTH), also the stage count

  // ALU opcodes for the shift group; the decoder uses the same values.
  localparam logic [4:0] ALU_OP_SLL = 5'b00100;
  localparam logic [4:0] ALU_OP_SRA = 5'b00101;
  localparam logic [4:0] ALU_OP_SRL = 5'b00110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sr_state_t;

endpackage

// File: rtl/shift_right_seq_sr_stage.sv
// sr_stage: combinational single log-stage right shifter.
//   value_i  : value to shift
//   stage_i  : stage index k, shift distance is 2^k (k = 0..4)
//   en_i     : 1 = apply the shift, 0 = pass value through
//   fill_i   : bit shifted into the vacated MSBs
//   value_o  : shifted value
module sr_stage
  import alu_pkg::*;
(
  input  logic [SR_WIDTH-1:0] value_i,
  input  logic [2:0]          stage_i,
  input  logic                en_i,
  input  logic                fill_i,
  output logic [SR_WIDTH-1:0] value_o
);

  always_comb begin
    value_o = value_i;
    if (en_i) begin
      case (stage_i)
        3'd0:    value_o = {{1{fill_i}},  value_i[SR_WIDTH-1:1]};
        3'd1:    value_o = {{2{fill_i}},  value_i[SR_WIDTH-1:2]};
        3'd2:    value_o = {{4{fill_i}},  value_i[SR_WIDTH-1:4]};
        3'd3:    value_o = {{8{fill_i}},  value_i[SR_WIDTH-1:8]};
        3'd4:    value_o = {{16{fill_i}}, value_i[SR_WIDTH-1:16]};
        default: value_o = value_i;
      endcase
    end
  end

endmodule

// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-cycle 32-bit right shifter (SRL / SRA), one log
// stage (1, 2, 4, 8, 16) per cycle, fixed 5-edge latency.
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   ctrl_start      : request, sampled only in IDLE
//   ctrl_arith      : 1 = arithmetic (sign fill), 0 = logical (zero fill)
//   data_operandA   : value to shift
//   ctrl_shiftamt   : shift amount 0..31
//   data_result     : result, held until the next accepted start
//   data_resultRDY  : one-cycle pulse while in DONE
//   busy            : high from the cycle after acceptance through DONE
module shift_right_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = SR_WIDTH,
  parameter int unsigned SHAMT_W = SR_SHAMT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_start,
  input  logic               ctrl_arith,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_resultRDY,
  output logic               busy
);

  sr_state_t          state_q,  state_d;
  logic [WIDTH-1:0]   acc_q,    acc_d;
  logic [SHAMT_W-1:0] shamt_q,  shamt_d;
  logic               arith_q,  arith_d;
  logic [2:0]         k_q,      k_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               rdy_q,    rdy_d;
  logic               busy_q,   busy_d;

  logic [WIDTH-1:0]   stage_out;
  logic               fill;

  // acc[31] is invariant under an arithmetic shift, so it always carries the
  // sign of the captured operand.
  assign fill = arith_q & acc_q[WIDTH-1];

  // shamt_q is shifted down each stage so bit 0 is always the enable for
  // the current stage k.
  sr_stage u_stage (
    .value_i (acc_q),
    .stage_i (k_q),
    .en_i    (shamt_q[0]),
    .fill_i  (fill),
    .value_o (stage_out)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    shamt_d  = shamt_q;
    arith_d  = arith_q;
    k_d      = k_q;
    result_d = result_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_start) begin
          acc_d   = data_operandA;
          shamt_d = ctrl_shiftamt;
          arith_d = ctrl_arith;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d   = stage_out;
        shamt_d = shamt_q >> 1;
        if (k_q == 3'd4) begin
          result_d = stage_out;
          rdy_d    = 1'b1;
          k_d      = '0;
          state_d  = ST_DONE;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      shamt_q  <= '0;
      arith_q  <= 1'b0;
      k_q      <= '0;
      result_q <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      shamt_q  <= shamt_d;
      arith_q  <= arith_d;
      k_q      <= k_d;
      result_q <= result_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule
